// File: rtl/sevenseg_capture.sv
// Seven-segment bus monitor: settles each anode strobe, decodes the glyph to a nibble,
// and publishes a 16-bit value once all four digits have been captured.
module sevenseg_capture #(
  parameter int SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        an_err
);

  // state    | meaning
  // IDLE     | no single anode active; waiting for a strobe
  // SETTLE   | one anode low; counting stable cycles before sampling
  // HOLD     | digit captured; waiting for the anode to move on
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  localparam logic [7:0] SETTLE_C  = 8'(SETTLE);
  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

  logic [6:0]  r_seg_q, r_seg_p;
  logic [3:0]  r_an_q, r_an_p;
  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic [3:0]  r_seen;
  logic [15:0] r_shadow;
  logic [3:0]  r_shadow_err;
  logic [15:0] r_value;
  logic [3:0]  r_digit_err;
  logic        r_frame_valid;
  logic        r_an_err;

  logic        w_one_low;
  logic        w_multi;
  logic        w_changed;
  logic        w_an_changed;
  logic [1:0]  w_slot;
  logic [4:0]  w_dec;
  logic        w_capture;

  function automatic logic [4:0] f_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40:   r = 5'h00;
      7'h79:   r = 5'h01;
      7'h24:   r = 5'h02;
      7'h30:   r = 5'h03;
      7'h19:   r = 5'h04;
      7'h12:   r = 5'h05;
      7'h02:   r = 5'h06;
      7'h78:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h18:   r = 5'h09;
      7'h08:   r = 5'h0A;
      7'h03:   r = 5'h0B;
      7'h46:   r = 5'h0C;
      7'h21:   r = 5'h0D;
      7'h06:   r = 5'h0E;
      7'h0E:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  always_comb begin
    w_one_low = 1'b1;
    w_slot    = 2'd0;
    case (r_an_q)
      4'b1110: w_slot = 2'd0;
      4'b1101: w_slot = 2'd1;
      4'b1011: w_slot = 2'd2;
      4'b0111: w_slot = 2'd3;
      default: w_one_low = 1'b0;
    endcase
  end

  // Neither a single strobe nor blanking means two or more anodes are low.
  assign w_multi      = !w_one_low && (r_an_q != 4'hF);
  assign w_an_changed = (r_an_q != r_an_p);
  assign w_changed    = w_an_changed || (r_seg_q != r_seg_p);
  assign w_dec        = f_decode(r_seg_q);
  assign w_capture    = (r_state == ST_SETTLE) && !w_multi && !w_changed &&
                        (r_cnt == SETTLE_M1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_q       <= 7'h7F;
      r_seg_p       <= 7'h7F;
      r_an_q        <= 4'hF;
      r_an_p        <= 4'hF;
      r_state       <= ST_IDLE;
      r_cnt         <= 8'd0;
      r_seen        <= 4'd0;
      r_shadow      <= 16'd0;
      r_shadow_err  <= 4'd0;
      r_value       <= 16'd0;
      r_digit_err   <= 4'd0;
      r_frame_valid <= 1'b0;
      r_an_err      <= 1'b0;
    end else begin
      r_seg_q       <= seg;
      r_an_q        <= an;
      r_seg_p       <= r_seg_q;
      r_an_p        <= r_an_q;
      r_an_err      <= w_multi;
      r_frame_valid <= 1'b0;

      if (w_multi) begin
        r_state <= ST_IDLE;
        r_cnt   <= 8'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_one_low) begin
              r_cnt   <= 8'd1;
              r_state <= ST_SETTLE;
            end else begin
              r_cnt <= 8'd0;
            end
          end
          ST_SETTLE: begin
            if (w_changed) begin
              if (w_one_low) begin
                r_cnt <= 8'd1;
              end else begin
                r_cnt   <= 8'd0;
                r_state <= ST_IDLE;
              end
            end else begin
              if (r_cnt < SETTLE_C) r_cnt <= r_cnt + 8'd1;
              if (r_cnt == SETTLE_M1) r_state <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (w_an_changed) begin
              if (w_one_low) begin
                r_cnt   <= 8'd1;
                r_state <= ST_SETTLE;
              end else begin
                r_cnt   <= 8'd0;
                r_state <= ST_IDLE;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
          end
        endcase
      end

      if (w_capture) begin
        r_shadow[{w_slot, 2'b00} +: 4] <= w_dec[3:0];
        r_shadow_err[w_slot]           <= w_dec[4];
      end

      // A full seen mask publishes the shadow one cycle after the completing capture.
      if (r_seen == 4'hF) begin
        r_value       <= r_shadow;
        r_digit_err   <= r_shadow_err;
        r_frame_valid <= 1'b1;
        r_seen        <= 4'd0;
      end else if (w_capture) begin
        r_seen[w_slot] <= 1'b1;
      end
    end
  end

  assign value       = r_value;
  assign digit_err   = r_digit_err;
  assign frame_valid = r_frame_valid;
  assign an_err      = r_an_err;

endmodule
